// File: rtl/baccarat_pkg.sv
// Shared baccarat types, rule thresholds and card decoding.
// Imported by the control FSM and the banker third-card rule block.
package baccarat_pkg;

  typedef enum logic [3:0] {
    ST_RST     = 4'd0,
    ST_DEAL_P1 = 4'd1,
    ST_DEAL_D1 = 4'd2,
    ST_DEAL_P2 = 4'd3,
    ST_DEAL_D2 = 4'd4,
    ST_EVAL2   = 4'd5,
    ST_DEAL_P3 = 4'd6,
    ST_EVAL_D  = 4'd7,
    ST_DEAL_D3 = 4'd8,
    ST_DONE    = 4'd9
  } state_t;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
  localparam logic [3:0] DEALER_STAND    = 4'd7;

  // Ace..9 count face value; 10, J, Q, K and the "no card" code count zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if (code >= 4'd1 && code <= 4'd9) begin
      return code;
    end
    return 4'd0;
  endfunction

endpackage

// File: rtl/banker_draw.sv
// Banker tableau: decides whether the dealer takes a third card given the
// dealer total and the player's third card. Purely combinational.
module banker_draw
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  always_comb begin
    v    = card_value(pcard3);
    draw = 1'b0;
    if (dscore >= DEALER_STAND) begin
      draw = 1'b0;
    end else begin
      case (dscore)
        4'd0, 4'd1, 4'd2: draw = 1'b1;
        4'd3:             draw = (v != 4'd8);
        4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
        4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
        4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
        default:          draw = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/statemachine.sv
// Baccarat hand sequencer: deals four cards, applies third-card rules, lights
// the winner. One hand per reset. Optional STATE_DEBUG_EN adds state_dbg.
module statemachine
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
`ifdef STATE_DEBUG_EN
  ,
  output logic [3:0] state_dbg
`endif
);

  state_t state;
  state_t state_nxt;
  logic   dealer_draws;
  logic   natural;
  logic   done;

  banker_draw u_banker_draw (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (dealer_draws)
  );

  assign natural = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);

  always_comb begin
    state_nxt = ST_RST;
    case (state)
      ST_RST:     state_nxt = ST_DEAL_P1;
      ST_DEAL_P1: state_nxt = ST_DEAL_D1;
      ST_DEAL_D1: state_nxt = ST_DEAL_P2;
      ST_DEAL_P2: state_nxt = ST_DEAL_D2;
      ST_DEAL_D2: state_nxt = ST_EVAL2;
      ST_EVAL2: begin
        if (natural) begin
          state_nxt = ST_DONE;
        end else if (pscore <= PLAYER_DRAW_MAX) begin
          state_nxt = ST_DEAL_P3;
        end else if (dscore <= PLAYER_DRAW_MAX) begin
          // Player stood on 6/7; the dealer draws on 0-5 regardless.
          state_nxt = ST_DEAL_D3;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_DEAL_P3: state_nxt = ST_EVAL_D;
      ST_EVAL_D:  state_nxt = dealer_draws ? ST_DEAL_D3 : ST_DONE;
      ST_DEAL_D3: state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_DONE;
      default:    state_nxt = ST_RST;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Moore strobes follow the state register, so reset drops them at once.
  assign load_pcard1 = (state == ST_DEAL_P1);
  assign load_dcard1 = (state == ST_DEAL_D1);
  assign load_pcard2 = (state == ST_DEAL_P2);
  assign load_dcard2 = (state == ST_DEAL_D2);
  assign load_pcard3 = (state == ST_DEAL_P3);
  assign load_dcard3 = (state == ST_DEAL_D3);

  assign done             = (state == ST_DONE);
  assign player_win_light = done && (pscore >= dscore);
  assign dealer_win_light = done && (dscore >= pscore);

`ifdef STATE_DEBUG_EN
  assign state_dbg = state;
`endif

endmodule

// File: tb/tb_statemachine.sv
// Directed table-driven bench for the baccarat control FSM.
module tb_statemachine;

  logic       slow_clock;
  logic       resetb;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
`ifdef STATE_DEBUG_EN
  logic [3:0] state_dbg;
`endif

  int checks;
  int failures;

  statemachine dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
`ifdef STATE_DEBUG_EN
    ,
    .state_dbg        (state_dbg)
`endif
  );

  // Clock / reset block
  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  // Strobe bit order: {d3, p3, d2, p2, d1, p1}
  function automatic logic [5:0] strobes();
    return {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] ps2, ds2, pc3;   // scores at EVAL2, player third card code
    logic [3:0] psm, dsm;        // scores after player third card (EVAL_D)
    logic [3:0] psf, dsf;        // final scores after the hand completes
    logic       exp_p3, exp_d3;
    int         exp_done;        // edge after reset release that enters DONE
    logic       exp_pw, exp_dw;
  } hand_t;

  hand_t hands[11];

  task automatic init_table();
    //            ps2   ds2   pc3    psm   dsm   psf   dsf   p3    d3   done pw    dw
    hands[0]  = '{4'd8, 4'd3, 4'd0,  4'd8, 4'd3, 4'd8, 4'd3, 1'b0, 1'b0, 6, 1'b1, 1'b0};
    hands[1]  = '{4'd4, 4'd5, 4'd6,  4'd7, 4'd5, 4'd7, 4'd7, 1'b1, 1'b1, 9, 1'b1, 1'b1};
    hands[2]  = '{4'd2, 4'd3, 4'd8,  4'd0, 4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 8, 1'b0, 1'b1};
    hands[3]  = '{4'd6, 4'd4, 4'd0,  4'd6, 4'd4, 4'd6, 4'd9, 1'b0, 1'b1, 7, 1'b0, 1'b1};
    hands[4]  = '{4'd3, 4'd6, 4'd12, 4'd3, 4'd6, 4'd3, 4'd6, 1'b1, 1'b0, 8, 1'b0, 1'b1};
    hands[5]  = '{4'd1, 4'd2, 4'd13, 4'd1, 4'd2, 4'd1, 4'd5, 1'b1, 1'b1, 9, 1'b0, 1'b1};
    hands[6]  = '{4'd7, 4'd9, 4'd0,  4'd7, 4'd9, 4'd7, 4'd9, 1'b0, 1'b0, 6, 1'b0, 1'b1};
    hands[7]  = '{4'd7, 4'd7, 4'd0,  4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 1'b0, 6, 1'b1, 1'b1};
    hands[8]  = '{4'd5, 4'd6, 4'd7,  4'd2, 4'd6, 4'd2, 4'd6, 1'b1, 1'b1, 9, 1'b0, 1'b1};
    hands[9]  = '{4'd0, 4'd4, 4'd1,  4'd1, 4'd4, 4'd1, 4'd4, 1'b1, 1'b0, 8, 1'b0, 1'b1};
    hands[10] = '{4'd5, 4'd5, 4'd3,  4'd8, 4'd5, 4'd8, 4'd5, 1'b1, 1'b0, 8, 1'b1, 1'b0};
  endtask

  function automatic logic [5:0] exp_strobe(input hand_t h, input int edge_n);
    case (edge_n)
      1: return 6'b000001;
      2: return 6'b000010;
      3: return 6'b000100;
      4: return 6'b001000;
      6: begin
        if (h.exp_p3) return 6'b010000;
        if (h.exp_d3) return 6'b100000;
        return 6'b000000;
      end
      8: return (h.exp_p3 && h.exp_d3) ? 6'b100000 : 6'b000000;
      default: return 6'b000000;
    endcase
  endfunction

  // Driver: reset, release on a falling edge, return just before edge 1.
  task automatic apply_reset(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc);
    resetb = 1'b0;
    pscore = ps;
    dscore = ds;
    pcard3 = pc;
    #3;
    check("reset_strobes", {26'd0, strobes()}, 32'd0);
    check("reset_lights", {30'd0, player_win_light, dealer_win_light}, 32'd0);
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  task automatic run_hand(input int idx);
    hand_t h;
    int    done_edge;
    h = hands[idx];
    done_edge = 0;
    apply_reset(h.ps2, h.ds2, h.pc3);
    for (int e = 1; e <= 12; e++) begin
      @(posedge slow_clock);
      #1;
      check($sformatf("hand%0d_strobe_e%0d", idx, e), {26'd0, strobes()},
            {26'd0, exp_strobe(h, e)});
      if (done_edge == 0 && (player_win_light || dealer_win_light)) done_edge = e;
      if (e == 6) begin
        pscore = h.psm;
        dscore = h.dsm;
      end
      if (e == 9) begin
        pscore = h.psf;
        dscore = h.dsf;
      end
    end
    #1;
    check($sformatf("hand%0d_done_edge", idx), done_edge, h.exp_done);
    check($sformatf("hand%0d_lights", idx), {30'd0, player_win_light, dealer_win_light},
          {30'd0, h.exp_pw, h.exp_dw});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetb   = 1'b0;
    pscore   = 4'd0;
    dscore   = 4'd0;
    pcard3   = 4'd0;
    init_table();

    for (int i = 0; i < 11; i++) begin
      run_hand(i);
    end

    // Reset asserted mid-hand while load_pcard2 is high.
    apply_reset(4'd4, 4'd4, 4'd0);
    repeat (3) @(posedge slow_clock);
    #1;
    check("midreset_p2_high", {31'd0, load_pcard2}, 32'd1);
    #2;
    resetb = 1'b0;
    #1;
    check("midreset_async_drop", {26'd0, strobes()}, 32'd0);
    @(negedge slow_clock);
    resetb = 1'b1;
    #1;
    check("midreset_rst_idle", {26'd0, strobes()}, 32'd0);
    @(posedge slow_clock);
    #1;
    check("midreset_restart_p1", {26'd0, strobes()}, 32'd1);
    @(posedge slow_clock);
    #1;
    check("midreset_restart_d1", {26'd0, strobes()}, 32'd2);

`ifdef STATE_DEBUG_EN
    check("state_dbg_d1", {28'd0, state_dbg}, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected bench to finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/statemachine.md
Name: statemachine

Overview:
- Baccarat control FSM; sits directly upstream of the card datapath.
- Sequences the deal, issues one-hot load strobes for the six card registers and applies the tableau (third-card) rules to the live player/dealer scores.
- Drives the win lights once the hand is complete.
- One hand per reset.

Parameters:
- None. Rule thresholds are fixed constants held in the shared package.

Ports:
- slow_clock  in  1  system tick; state advances on the rising edge.
- resetb  in  1  asynchronous active-low reset.
- pscore  in  4  player total 0–9, from the datapath.
- dscore  in  4  dealer total 0–9, from the datapath.
- pcard3  in  4  player third-card code: 0 = none, 1 = A … 13 = K.
- load_pcard1, load_pcard2, load_pcard3  out  1 each  player card load strobes.
- load_dcard1, load_dcard2, load_dcard3  out  1 each  dealer card load strobes.
- player_win_light  out  1  player wins, or tie.
- dealer_win_light  out  1  dealer wins, or tie.

Behaviour:
- States in order: RST, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL2, DEAL_P3, EVAL_D, DEAL_D3, DONE.
- Reset: async on resetb=0 forces RST. All strobes and both lights are 0 during reset and in RST.
- Deal sequence: RST→DEAL_P1→DEAL_D1→DEAL_P2→DEAL_D2→EVAL2, one slow_clock cycle each.
- Outputs are Moore decodes of state:
  - DEAL_P1 → load_pcard1, DEAL_D1 → load_dcard1, DEAL_P2 → load_pcard2, DEAL_D2 → load_dcard2, DEAL_P3 → load_pcard3, DEAL_D3 → load_dcard3.
  - At most one strobe is high in any cycle.
  - Each strobe is high for exactly one full cycle. The datapath latches on the falling edge inside that cycle, so scores are valid at the next rising edge.
- EVAL2 (scores reflect 4 cards):
  - pscore≥8 or dscore≥8 (natural) → DONE.
  - Else pscore≤5 → DEAL_P3.
  - Else (player stands on 6/7): dscore≤5 → DEAL_D3, otherwise → DONE.
- DEAL_P3 → EVAL_D unconditionally.
- EVAL_D: compute v = value(pcard3), where codes 1–9 map to their value and 10–13 map to 0. Dealer draws (→DEAL_D3) when:
  - dscore 0–2: always.
  - dscore 3: v≠8.
  - dscore 4: v in 2..7.
  - dscore 5: v in 4..7.
  - dscore 6: v in 6..7.
  - dscore 7: never.
  - If the dealer does not draw → DONE.
- DEAL_D3 → DONE.
- DONE is absorbing; it is left only by reset.
- Lights are asserted only in DONE, decoded combinationally from the scores:
  - pscore>dscore → player_win_light=1.
  - dscore>pscore → dealer_win_light=1.
  - Equal → both lights 1.
- Score inputs are sampled only in EVAL2, EVAL_D and DONE; their values in other states are ignored.
- pcard3=0 in EVAL_D is unreachable in normal flow and is treated as v=0.
- Reset mid-hand (any state): immediate return to RST, with strobes dropping asynchronously.
- Unused state encodings → RST at the next edge.
- Latency: shortest hand is 6 edges from reset release to DONE; longest is 9.

Optional Feature:
- Macro STATE_DEBUG_EN.
- Defined: adds output state_dbg[3:0] = current state encoding (RST=0 … DONE=9) for LED debug; reset value 0.
- Undefined: the port is absent; behaviour is otherwise identical.

Decomposition:
- baccarat_pkg holds:
  - typedef enum logic[3:0] state_t.
  - Constants NATURAL_MIN=8, PLAYER_DRAW_MAX=5, DEALER_STAND=7.
  - Function card_value(code) returning 0–9.
- Sub-module banker_draw: combinational; inputs dscore and pcard3, output draw. Verified standalone over all 8×14 input combinations.

Test Plan:
- Natural: pscore=8, dscore=3 at EVAL2 → DONE without load_pcard3/load_dcard3 ever pulsing; player_win_light=1, dealer_win_light=0.
- Player draws, dealer conditional: pscore=4, dscore=5; pcard3=6 with pscore→7, dscore→7 → load_dcard3 pulses once; both lights 1 (tie).
- Dealer stands on a 3 with pcard3=8: pscore=2, dscore=3, pcard3=8 → no load_dcard3; final pscore=0 → dealer_win_light=1 only.
- Player stands, dealer draws: pscore=6, dscore=4 → no load_pcard3, load_dcard3 pulses once; final dscore=9 → dealer_win_light=1.
- Face-card third card: dscore=6, pcard3=12 (v=0) → dealer stands, DONE in 8 edges.
- Reset asserted during DEAL_P2 → all strobes 0 immediately. After release, sequence restarts: load_pcard1 high exactly 1 cycle after RST.
